// File: rtl/conv3x3_stream.sv
// conv3x3_stream: streaming valid-only 3x3 convolution with NUM_FILT parallel
// filters over an IMG_W x IMG_H raster frame.
// Optional feature: define CONV_RELU_EN to clamp negative filter results to 0.
//
// state  | meaning
// IDLE   | waiting for start; weight writes allowed
// STREAM | accepting frame pixels in raster order
// FLUSH  | all pixels taken, waiting for the last result to drain
module conv3x3_stream #(
  parameter int IMG_W    = 12,
  parameter int IMG_H    = 12,
  parameter int PIX_W    = 2,
  parameter int WGT_W    = 2,
  parameter int NUM_FILT = 4
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     start,
  input  logic                                     wgt_we,
  input  logic [$clog2(NUM_FILT*9)-1:0]            wgt_addr,
  input  logic [WGT_W-1:0]                         wgt_data,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [PIX_W-1:0]                         in_pix,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [NUM_FILT*(PIX_W+WGT_W+5)-1:0]      out_data,
  output logic [$clog2(IMG_H)-1:0]                 out_row,
  output logic [$clog2(IMG_W)-1:0]                 out_col,
  output logic                                     busy,
  output logic                                     done
);

  localparam int ACC_W = PIX_W + WGT_W + 5;
  localparam int NTAP  = NUM_FILT * 9;
  localparam int RW    = $clog2(IMG_H);
  localparam int CW    = $clog2(IMG_W);
  localparam int LB_D  = IMG_W - 1;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  state_t state, state_nx;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic signed [WGT_W-1:0] wgt [NTAP];
  logic [PIX_W-1:0] lb0 [LB_D];
  logic [PIX_W-1:0] lb1 [LB_D];
  logic [PIX_W-1:0] win [3][3];
  logic [PIX_W-1:0] nwin [3][3];
  logic signed [ACC_W-1:0] acc [NUM_FILT];
  logic [NUM_FILT*ACC_W-1:0] res;
  logic accept, col_last, last_pix, emit, pending;

  assign in_ready = (state == STREAM) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign col_last = (col == CW'(IMG_W - 1));
  assign last_pix = col_last && (row == RW'(IMG_H - 1));
  assign emit     = accept && (row >= RW'(2)) && (col >= CW'(2));
  assign pending  = out_valid && !out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state decode plus busy/done flags
  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    done     = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = STREAM;
      end
      STREAM: if (accept && last_pix) state_nx = FLUSH;
      FLUSH: begin
        if (!pending) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Raster position of the next pixel to be accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (state == IDLE && start) begin
      row <= '0;
      col <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= last_pix ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Weight file: writable only while idle, out-of-range addresses dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAP; i++) wgt[i] <= '0;
    end else if (wgt_we && state == IDLE && int'(wgt_addr) < NTAP) begin
      wgt[wgt_addr] <= wgt_data;
    end
  end

  // Line buffers and window shift; contents are don't-care until refilled
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[0] <= win[2][2];
      lb1[0] <= win[1][2];
      for (int i = 1; i < LB_D; i++) begin
        lb0[i] <= lb0[i-1];
        lb1[i] <= lb1[i-1];
      end
      for (int ky = 0; ky < 3; ky++)
        for (int kx = 0; kx < 3; kx++)
          win[ky][kx] <= nwin[ky][kx];
    end
  end

  // Window as it will look after this accept, and the filter sums on it
  always_comb begin
    for (int ky = 0; ky < 3; ky++)
      for (int kx = 0; kx < 2; kx++)
        nwin[ky][kx] = win[ky][kx+1];
    nwin[0][2] = lb1[LB_D-1];
    nwin[1][2] = lb0[LB_D-1];
    nwin[2][2] = in_pix;
    res = '0;
    for (int f = 0; f < NUM_FILT; f++) begin
      acc[f] = '0;
      for (int ky = 0; ky < 3; ky++)
        for (int kx = 0; kx < 3; kx++)
          acc[f] = acc[f] + ACC_W'(signed'({1'b0, nwin[ky][kx]})) * ACC_W'(wgt[f*9 + ky*3 + kx]);
`ifdef CONV_RELU_EN
      res[f*ACC_W +: ACC_W] = acc[f][ACC_W-1] ? '0 : acc[f];
`else
      res[f*ACC_W +: ACC_W] = acc[f];
`endif
    end
  end

  // Output holding register with valid/ready handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_data  <= res;
      out_row   <= row - RW'(2);
      out_col   <= col - CW'(2);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed bench for conv3x3_stream: expected results are computed from the
// bench's own image/weight copies, queued on pixel accept and compared as the
// design presents each result.
module tb_conv3x3_stream;
  localparam int IMG_W = 12, IMG_H = 12, PIX_W = 2, WGT_W = 2, NUM_FILT = 4;
  localparam int ACC_W = PIX_W + WGT_W + 5;
  localparam int OW    = NUM_FILT * ACC_W;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int NOUT  = (IMG_W - 2) * (IMG_H - 2);
  localparam int AW    = $clog2(NUM_FILT * 9);
  localparam int RW    = $clog2(IMG_H);
  localparam int CW    = $clog2(IMG_W);

  logic clk, rst_n, start, wgt_we, in_valid, in_ready, out_valid, out_ready, busy, done;
  logic [AW-1:0] wgt_addr;
  logic [WGT_W-1:0] wgt_data;
  logic [PIX_W-1:0] in_pix;
  logic [OW-1:0] out_data;
  logic [RW-1:0] out_row;
  logic [CW-1:0] out_col;

  typedef struct {
    logic [OW-1:0] d;
    int r;
    int c;
  } exp_t;

  exp_t q[$];
  int img [IMG_H][IMG_W];
  int wm [NUM_FILT][9];
  int checks = 0, failures = 0;
  int out_cnt, done_cnt;
  bit ctr_mode = 0, const_mode = 0;

  conv3x3_stream #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W), .WGT_W(WGT_W),
                   .NUM_FILT(NUM_FILT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .wgt_we(wgt_we), .wgt_addr(wgt_addr),
    .wgt_data(wgt_data), .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .busy(busy), .done(done));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OW-1:0] model(input int r, input int c);
    logic [OW-1:0] res;
    logic [31:0] sv;
    int s;
    res = '0;
    for (int f = 0; f < NUM_FILT; f++) begin
      s = 0;
      for (int ky = 0; ky < 3; ky++)
        for (int kx = 0; kx < 3; kx++)
          s += img[r-2+ky][c-2+kx] * wm[f][3*ky+kx];
`ifdef CONV_RELU_EN
      if (s < 0) s = 0;
`endif
      sv = s;
      res[f*ACC_W +: ACC_W] = sv[ACC_W-1:0];
    end
    return res;
  endfunction

  task automatic wr_w(input int addr, input int val);
    logic [31:0] v;
    v = val;
    wgt_we = 1'b1;
    wgt_addr = AW'(addr);
    wgt_data = v[WGT_W-1:0];
    @(posedge clk); @(negedge clk);
    wgt_we = 1'b0;
  endtask

  task automatic rand_weights();
    int v;
    for (int a = 0; a < NUM_FILT*9; a++) begin
      v = int'($urandom_range(0, 3));
      if (v >= 2) v -= 4;
      wr_w(a, v);
      wm[a/9][a%9] = v;
    end
  endtask

  task automatic rand_image();
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        img[r][c] = int'($urandom_range(0, 3));
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_row", 64'(out_row), 64'd0);
    chk("rst_out_col", 64'(out_col), 64'd0);
  endtask

  // Streams nframes frames; optional out_ready stall, busy-time weight write, abort point
  task automatic stream(input int nframes, input int stall_at, input int wr_at,
                        input int abort_at, input bit hold_start);
    int pix, stall, cyc, r, c;
    logic [OW-1:0] hd;
    logic [RW-1:0] hr;
    logic [CW-1:0] hc;
    logic [ACC_W-1:0] kexp;
    exp_t e;
`ifdef CONV_RELU_EN
    kexp = '0;
`else
    kexp = ACC_W'(-54);
`endif
    pix = 0; stall = 0; cyc = 0; out_cnt = 0; done_cnt = 0;
    hd = '0; hr = '0; hc = '0;
    start = 1'b1;
    while (done_cnt < nframes && cyc < 3000 * nframes) begin
      if (abort_at >= 0 && pix == abort_at) break;
      in_valid = (pix < nframes * NPIX);
      in_pix = PIX_W'(img[(pix % NPIX) / IMG_W][pix % IMG_W]);
      wgt_we = (pix == wr_at);
      wgt_addr = AW'(4);
      wgt_data = 2'b11;
      out_ready = 1'b1;
      if (stall_at >= 0 && pix >= stall_at && stall < 20 && out_valid) out_ready = 1'b0;
      #1;
      if (!out_ready) begin
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        if (stall == 0) begin
          hd = out_data; hr = out_row; hc = out_col;
        end else begin
          chk("stall_data", 64'(out_data), 64'(hd));
          chk("stall_row", 64'(out_row), 64'(hr));
          chk("stall_col", 64'(out_col), 64'(hc));
        end
        stall++;
      end
      if (out_valid && out_ready) begin
        chk("out_expected", 64'(q.size() > 0), 64'd1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("out_data", 64'(out_data), 64'(e.d));
          chk("out_row", 64'(out_row), 64'(e.r));
          chk("out_col", 64'(out_col), 64'(e.c));
        end
        if (ctr_mode)
          chk("center_tap", 64'(out_data[ACC_W-1:0]),
              64'(img[int'(out_row)+1][int'(out_col)+1]));
        if (const_mode)
          for (int f = 0; f < NUM_FILT; f++)
            chk("const_field", 64'(out_data[f*ACC_W +: ACC_W]), 64'(kexp));
        out_cnt++;
      end
      if (in_valid && in_ready) begin
        r = (pix % NPIX) / IMG_W;
        c = pix % IMG_W;
        if (r >= 2 && c >= 2) begin
          e.d = model(r, c); e.r = r - 2; e.c = c - 2;
          q.push_back(e);
        end
        pix++;
      end
      if (done) done_cnt++;
      @(posedge clk); @(negedge clk);
      cyc++;
      if (!hold_start && busy) start = 1'b0;
    end
    start = 1'b0; in_valid = 1'b0; wgt_we = 1'b0; out_ready = 1'b1;
    if (abort_at < 0) begin
      #1;
      chk("no_timeout", 64'(cyc < 3000 * nframes), 64'd1);
      chk("done_count", 64'(done_cnt), 64'(nframes));
      chk("out_count", 64'(out_cnt), 64'(nframes * NOUT));
      chk("queue_empty", 64'(q.size()), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_done", 64'(done), 64'd0);
      chk("idle_in_ready", 64'(in_ready), 64'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; wgt_we = 1'b0; wgt_addr = '0; wgt_data = '0;
    in_valid = 1'b0; in_pix = '0; out_ready = 1'b1;
    for (int f = 0; f < NUM_FILT; f++)
      for (int t = 0; t < 9; t++) wm[f][t] = 0;
    #12;
    chk_reset_outputs();
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // center tap of filter 0, out-of-range writes ignored, stall mid-frame
    wr_w(4, 1); wm[0][4] = 1;
    wr_w(40, 1);
    wr_w(63, -1);
    rand_image();
    ctr_mode = 1;
    stream(1, 60, -1, -1, 0);
    ctr_mode = 0;

    // write attempted during STREAM must not land, in this or the next frame
    rand_weights();
    rand_image();
    stream(1, -1, 30, -1, 0);
    rand_image();
    stream(1, -1, -1, -1, 0);

    // all weights -2, all pixels 3
    for (int a = 0; a < NUM_FILT*9; a++) begin
      wr_w(a, -2); wm[a/9][a%9] = -2;
    end
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++) img[r][c] = 3;
    const_mode = 1;
    stream(1, -1, -1, -1, 0);
    const_mode = 0;

    // reset after 50 pixels; weights must come back as zero
    rand_weights();
    rand_image();
    stream(1, -1, -1, 50, 0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    q.delete();
    for (int f = 0; f < NUM_FILT; f++)
      for (int t = 0; t < 9; t++) wm[f][t] = 0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    rand_image();
    stream(1, -1, -1, -1, 0);
    rand_weights();
    rand_image();
    stream(1, -1, -1, -1, 0);

    // back-to-back frames with start held
    rand_weights();
    rand_image();
    stream(2, -1, -1, -1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
